// File: rtl/alu_shift_pkg.sv
// Shared constants for the iterative shifter: op codes, FSM states, default widths.
package alu_shift_pkg;

  localparam int DATA_LENGTH_DEF = 12;
  localparam int AMT_WIDTH_DEF   = 4;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-position shift/rotate; bit_out is the bit leaving the word.
module alu_shift_step
  import alu_shift_pkg::*;
#(
  parameter int DATA_LENGTH = DATA_LENGTH_DEF
) (
  input  logic [DATA_LENGTH-1:0] w,
  input  logic [1:0]             op,
  output logic [DATA_LENGTH-1:0] w_next,
  output logic                   bit_out
);

  always_comb begin
    w_next  = w;
    bit_out = 1'b0;
    case (op)
      OP_SLL: begin
        w_next  = {w[DATA_LENGTH-2:0], 1'b0};
        bit_out = w[DATA_LENGTH-1];
      end
      OP_SRL: begin
        w_next  = {1'b0, w[DATA_LENGTH-1:1]};
        bit_out = w[0];
      end
      OP_SRA: begin
        w_next  = {w[DATA_LENGTH-1], w[DATA_LENGTH-1:1]};
        bit_out = w[0];
      end
      OP_ROL: begin
        w_next  = {w[DATA_LENGTH-2:0], w[DATA_LENGTH-1]};
        bit_out = w[DATA_LENGTH-1];
      end
      default: begin
        w_next  = w;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// One-bit-per-cycle shifter/rotator feeding the ALU result register.
// Optional carry_out/zero flags are enabled by defining ALU_SHIFT_FLAGS_EN.
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int AMT_WIDTH   = AMT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [AMT_WIDTH-1:0]   amt,
  input  logic [DATA_LENGTH-1:0] operand,
  output logic                   busy,
  output logic                   done,
  output logic                   shift_en,
`ifdef ALU_SHIFT_FLAGS_EN
  output logic                   carry_out,
  output logic                   zero,
`endif
  output logic [DATA_LENGTH-1:0] result
);

  state_t                 state_reg, state_next;
  logic [DATA_LENGTH-1:0] work_reg, work_next;
  logic [1:0]             op_reg, op_next;
  logic [AMT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [DATA_LENGTH-1:0] result_reg, result_next;
  logic                   carry_reg, carry_next;
  logic                   zero_reg, zero_next;

  logic [DATA_LENGTH-1:0] step_w;
  logic                   step_bit;

  alu_shift_step #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_step (
    .w      (work_reg),
    .op     (op_reg),
    .w_next (step_w),
    .bit_out(step_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      work_reg   <= '0;
      op_reg     <= OP_SLL;
      cnt_reg    <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      work_reg   <= work_next;
      op_reg     <= op_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      carry_reg  <= carry_next;
      zero_reg   <= zero_next;
    end
  end

  // Result and flags load on the edge that enters DONE, so they are valid
  // during the done pulse and held until the next completion.
  always_comb begin
    state_next  = state_reg;
    work_next   = work_reg;
    op_next     = op_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    carry_next  = carry_reg;
    zero_next   = zero_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          work_next = operand;
          op_next   = op;
          cnt_next  = amt;
          if (amt != '0) begin
            state_next = ST_SHIFT;
          end else begin
            state_next  = ST_DONE;
            result_next = operand;
            carry_next  = 1'b0;
            zero_next   = (operand == '0);
          end
        end
      end
      ST_SHIFT: begin
        work_next = step_w;
        cnt_next  = cnt_reg - AMT_WIDTH'(1);
        if (cnt_reg == AMT_WIDTH'(1)) begin
          state_next  = ST_DONE;
          result_next = step_w;
          carry_next  = step_bit;
          zero_next   = (step_w == '0);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);
  assign shift_en = done;
  assign result   = result_reg;

`ifdef ALU_SHIFT_FLAGS_EN
  assign carry_out = carry_reg;
  assign zero      = zero_reg;
`else
  logic unused_flags;
  assign unused_flags = carry_reg ^ zero_reg;
`endif

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed-vector bench for alu_shift_seq; flag checks compile in with ALU_SHIFT_FLAGS_EN.
module tb_alu_shift_seq;
  import alu_shift_pkg::*;

  localparam int N  = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] amt;
  logic [N-1:0]  operand;
  logic          busy, done, shift_en;
  logic [N-1:0]  result;
`ifdef ALU_SHIFT_FLAGS_EN
  logic          carry_out, zero;
`endif

  always #5 clk = ~clk;

  alu_shift_seq #(.DATA_LENGTH(N), .AMT_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .amt      (amt),
    .operand  (operand),
    .busy     (busy),
    .done     (done),
    .shift_en (shift_en),
`ifdef ALU_SHIFT_FLAGS_EN
    .carry_out(carry_out),
    .zero     (zero),
`endif
    .result   (result)
  );

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] amt;
    logic [N-1:0]  operand;
    logic [N-1:0]  res;
    logic          c;
    logic          z;
  } vec_t;

  vec_t vecs[13];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".busy"},     32'(busy),     32'd0);
    check({tag, ".done"},     32'(done),     32'd0);
    check({tag, ".shift_en"}, 32'(shift_en), 32'd0);
    check({tag, ".result"},   32'(result),   32'd0);
`ifdef ALU_SHIFT_FLAGS_EN
    check({tag, ".carry"},    32'(carry_out), 32'd0);
    check({tag, ".zero"},     32'(zero),      32'd0);
`endif
  endtask

  // Issue one op, then check done/busy cycle by cycle up to amt+1 and one beyond.
  task automatic run_vec(input vec_t v, input int idx);
    int last;
    last = int'(v.amt) + 1;
    @(negedge clk);
    start = 1'b1; op = v.op; amt = v.amt; operand = v.operand;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~v.op; amt = ~v.amt; operand = ~v.operand;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      check($sformatf("v%0d.done@%0d", idx, k),     32'(done),     32'(k == last));
      check($sformatf("v%0d.shift_en@%0d", idx, k), 32'(shift_en), 32'(k == last));
      check($sformatf("v%0d.busy@%0d", idx, k),     32'(busy),     32'd1);
    end
    check($sformatf("v%0d.result", idx), 32'(result), 32'(v.res));
`ifdef ALU_SHIFT_FLAGS_EN
    check($sformatf("v%0d.carry", idx), 32'(carry_out), 32'(v.c));
    check($sformatf("v%0d.zero", idx),  32'(zero),      32'(v.z));
`endif
    @(negedge clk);
    check($sformatf("v%0d.done_after", idx), 32'(done),   32'd0);
    check($sformatf("v%0d.busy_after", idx), 32'(busy),   32'd0);
    check($sformatf("v%0d.result_hold", idx), 32'(result), 32'(v.res));
    $display("vec %0d: op=%0d amt=%0d operand=0x%03h -> result=0x%03h (expected 0x%03h)",
             idx, v.op, v.amt, v.operand, result, v.res);
  endtask

  initial begin
    int dones;
    vecs[0]  = '{OP_SLL, 4'd3,  12'h0A5, 12'h528, 1'b0, 1'b0};
    vecs[1]  = '{OP_SRA, 4'd4,  12'h800, 12'hF80, 1'b0, 1'b0};
    vecs[2]  = '{OP_SRL, 4'd15, 12'hFFF, 12'h000, 1'b0, 1'b1};
    vecs[3]  = '{OP_ROL, 4'd1,  12'h801, 12'h003, 1'b1, 1'b0};
    vecs[4]  = '{OP_ROL, 4'd13, 12'h801, 12'h003, 1'b1, 1'b0};
    vecs[5]  = '{OP_SLL, 4'd0,  12'h3C3, 12'h3C3, 1'b0, 1'b0};
    vecs[6]  = '{OP_SLL, 4'd12, 12'hFFF, 12'h000, 1'b1, 1'b1};
    vecs[7]  = '{OP_SRA, 4'd15, 12'h7FF, 12'h000, 1'b0, 1'b1};
    vecs[8]  = '{OP_SRA, 4'd15, 12'hA00, 12'hFFF, 1'b1, 1'b0};
    vecs[9]  = '{OP_SRL, 4'd4,  12'hABC, 12'h0AB, 1'b1, 1'b0};
    vecs[10] = '{OP_ROL, 4'd4,  12'h123, 12'h231, 1'b1, 1'b0};
    vecs[11] = '{OP_SLL, 4'd11, 12'h001, 12'h800, 1'b0, 1'b0};
    vecs[12] = '{OP_SRL, 4'd0,  12'h000, 12'h000, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; op = OP_SLL; amt = '0; operand = '0;
    #1;
    check_idle_zero("reset_init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Reset while idle with a non-zero held result clears outputs asynchronously.
    run_vec(vecs[0], 100);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_idle_zero("reset_idle");
    @(negedge clk);
    reset = 1'b0;
    $display("seq reset_idle: result=0x%03h busy=%0b", result, busy);

    // Reset at step 2 of an amt=5 op: aborted, no done afterwards.
    @(negedge clk);
    start = 1'b1; op = OP_SLL; amt = 4'd5; operand = 12'h0A5;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid.busy_before", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1 check_idle_zero("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid.no_done", 32'(dones), 32'd0);
    check("mid.busy_after", 32'(busy), 32'd0);
    $display("seq reset_mid: dones_after_abort=%0d result=0x%03h", dones, result);
    run_vec(vecs[3], 101);

    // start held every cycle with changing operands during an amt=6 op.
    @(negedge clk);
    start = 1'b1; op = OP_SLL; amt = 4'd6; operand = 12'h001;
    dones = 0;
    @(posedge clk);
    #1;
    operand = 12'(32'($urandom)); op = 2'($urandom); amt = 4'($urandom);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("b2b.busy@%0d", k), 32'(busy), 32'd1);
      check($sformatf("b2b.done@%0d", k), 32'(done), 32'(k == 7));
      if (done) dones++;
      if (k == 7) start = 1'b0;
      else begin
        operand = 12'(32'($urandom)); op = 2'($urandom); amt = 4'($urandom);
      end
    end
    check("b2b.result", 32'(result), 32'h040);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("b2b.single_done", 32'(dones), 32'd1);
    check("b2b.result_hold", 32'(result), 32'h040);
    $display("seq b2b: dones=%0d result=0x%03h (expected 0x040)", dones, result);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_shift_seq.md
Name: alu_shift_seq

Overview:
- Iterative one-bit-per-cycle shifter/rotator in the ALU datapath.
- Sits directly upstream of the ALU parallel-load result register.
- Accepts an operand, op code and shift amount on a start pulse, then shifts one position per clock.
- Presents the final word with a one-cycle load strobe that drives the downstream register's shift_en / data_in_p.

Parameters:
DATA_LENGTH, 12, operand/result width in bits
AMT_WIDTH, 4, shift-amount width; must satisfy 2**AMT_WIDTH > DATA_LENGTH-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROL
amt  input  AMT_WIDTH  number of single-bit steps
operand  input  DATA_LENGTH  word to shift
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse, result valid
shift_en  output  1  load strobe to downstream register; identical to done
result  output  DATA_LENGTH  shifted word, connects to downstream data_in_p

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: state=IDLE, busy=0, done=0, shift_en=0, result=0, working reg=0, counter=0.
- States:
  - IDLE: on start=1, latch operand into the working reg, latch op, load counter=amt. Go to SHIFT if amt!=0, else to DONE.
  - SHIFT: each cycle apply one step to the working reg and decrement counter. When counter==1 (last step), go to DONE.
  - DONE: result<=working reg (registered); done=shift_en=1 for exactly this cycle; go to IDLE.
- Single step per op:
  - SLL: {w[N-2:0],0}
  - SRL: {0,w[N-1:1]}
  - SRA: {w[N-1],w[N-1:1]}
  - ROL: {w[N-2:0],w[N-1]}
- Latency: done is asserted amt+1 clocks after the edge that samples start (amt=0 gives 1 clock).
- No back-to-back overlap: minimum start-to-start spacing is amt+2 clocks.
- amt >= DATA_LENGTH is legal and not clamped:
  - SLL/SRL give 0.
  - SRA gives all-sign.
  - ROL wraps naturally (amt mod DATA_LENGTH).
- start while busy=1 is ignored and not queued. operand, op and amt may change freely after capture.
- result holds its value between done pulses; it changes only in DONE.
- Reset mid-operation aborts immediately: no done, and result clears to 0.
- start asserted in the same cycle reset deasserts is not guaranteed to be captured.
- No arithmetic beyond the counter decrement; the counter never underflows because SHIFT is entered only with counter >= 1.

Optional Feature:
- Macro: ALU_SHIFT_FLAGS_EN.
- Defined: adds outputs carry_out (1) and zero (1), both registered in DONE alongside result. Both reset to 0.
  - carry_out = last bit shifted out of the word: w[N-1] for SLL/ROL, w[0] for SRL/SRA. It is 0 when amt=0.
  - zero = (result==0).
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_shift_pkg holds:
  - op encoding constants (OP_SLL, OP_SRL, OP_SRA, OP_ROL)
  - state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
  - default DATA_LENGTH/AMT_WIDTH constants
- One sub-module is natural: alu_shift_step, a combinational single-bit step taking (w, op) and giving (w_next, bit_out). It is parameterized by DATA_LENGTH.
- FSM, counter and output registers live in alu_shift_seq.

Test Plan:
- Reset during idle and during a SHIFT at step 2 of an amt=5 op -> all outputs 0, state IDLE, no done pulse, next start is accepted normally.
- SLL operand=0x0A5 amt=3 -> done/shift_en single pulse 4 clocks after start, result=0x528 (flags build: carry_out=0, zero=0).
- SRA operand=0x800 amt=4 -> result=0xF80; SRL operand=0xFFF amt=15 -> result=0x000 (flags build: zero=1).
- ROL operand=0x801 amt=1 -> result=0x003 (flags build: carry_out=1); ROL 0x801 amt=13 -> result=0x003.
- amt=0, operand=0x3C3 -> done 1 clock after start, result=0x3C3; busy high for exactly 1 cycle.
- start pulsed every cycle with changing operands during an amt=6 op -> only the first is captured, exactly one done, result reflects the first operand; busy stays high across all SHIFT/DONE cycles.
